// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for the 4x4 systolic array: turns one unskewed K-slice per
// handshake into the diagonal wavefront the array expects, and flags frame completion.
module systolic_skew_feeder #(
  parameter int DATA_W    = 16,
  parameter int ARRAY_LAT = 7,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_last,
  input  logic [4*DATA_W-1:0]   in_a,
  input  logic [4*DATA_W-1:0]   in_b,
  output logic [DATA_W-1:0]     a1,
  output logic [DATA_W-1:0]     a2,
  output logic [DATA_W-1:0]     a3,
  output logic [DATA_W-1:0]     a4,
  output logic [DATA_W-1:0]     b1,
  output logic [DATA_W-1:0]     b2,
  output logic [DATA_W-1:0]     b3,
  output logic [DATA_W-1:0]     b4,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Edges from the last accept until PE(4,4) holds its final product:
  // three extra skew stages on lane 4 plus the array's own latency.
  localparam logic [CNT_W-1:0] DRAIN_CYCLES = CNT_W'(3 + ARRAY_LAT);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              done_next;
  logic              accept;

  logic [DATA_W-1:0] a_out [4];
  logic [DATA_W-1:0] b_out [4];

  assign in_ready = (state != DRAIN);
  assign busy     = (state != IDLE);
  assign accept   = in_valid && in_ready;

  // NOTE: every variable gets its default before the case so no path can
  // leave one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    done_next  = 1'b0;
    unique case (state)
      IDLE, FEED: begin
        if (accept) begin
          if (in_last) begin
            state_next = DRAIN;
            cnt_next   = DRAIN_CYCLES;
          end else begin
            state_next = FEED;
          end
        end
      end
      DRAIN: begin
        if (cnt <= CNT_W'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      done  <= done_next;
    end
  end

  // Lane i is a chain of i+1 registers; idle cycles push zeros so bubbles
  // contribute zero products inside the array.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [DATA_W-1:0] a_st [i+1];
    logic [DATA_W-1:0] b_st [i+1];

    // NOTE: these small register arrays are plain flops, so they are reset
    // explicitly; a reset must flush in-flight data, not just the FSM.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s < i + 1; s++) begin
          a_st[s] <= '0;
          b_st[s] <= '0;
        end
      end else begin
        a_st[0] <= accept ? in_a[i*DATA_W +: DATA_W] : '0;
        b_st[0] <= accept ? in_b[i*DATA_W +: DATA_W] : '0;
        for (int s = 1; s < i + 1; s++) begin
          a_st[s] <= a_st[s-1];
          b_st[s] <= b_st[s-1];
        end
      end
    end

    assign a_out[i] = a_st[i];
    assign b_out[i] = b_st[i];
  end

  assign a1 = a_out[0];
  assign a2 = a_out[1];
  assign a3 = a_out[2];
  assign a4 = a_out[3];
  assign b1 = b_out[0];
  assign b2 = b_out[1];
  assign b3 = b_out[2];
  assign b4 = b_out[3];

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Directed bench for systolic_skew_feeder: per-cycle stimulus tables, outputs
// captured one step after each rising edge and compared to hand-derived values.
module tb_systolic_skew_feeder;

  localparam int MAXC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic [15:0] a1, a2, a3, a4, b1, b2, b3, b4;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  // Stimulus for cycle c is presented before edge c; observations follow edge c.
  logic        st_valid [MAXC];
  logic        st_last  [MAXC];
  logic [63:0] st_a     [MAXC];
  logic [63:0] st_b     [MAXC];
  bit          acc_exp  [MAXC];
  logic [15:0] ob_a     [MAXC][4];
  logic [15:0] ob_b     [MAXC][4];
  logic        ob_done  [MAXC];
  logic        ob_ready [MAXC];
  logic        ob_busy  [MAXC];

  systolic_skew_feeder dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .in_a     (in_a),
    .in_b     (in_b),
    .a1       (a1),
    .a2       (a2),
    .a3       (a3),
    .a4       (a4),
    .b1       (b1),
    .b2       (b2),
    .b3       (b3),
    .b4       (b4),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finished");
    $fatal(1);
  end

  function automatic logic [63:0] pack4(logic [15:0] l0, logic [15:0] l1,
                                        logic [15:0] l2, logic [15:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [15:0] lane_of(logic [63:0] v, int i);
    return v[16*i +: 16];
  endfunction

  // Lane i after edge c carries whatever was accepted at edge c-i, else zero.
  function automatic logic [15:0] exp_lane(bit is_b, int c, int i);
    int s;
    s = c - i;
    if (s < 1 || !acc_exp[s]) return 16'h0000;
    return is_b ? lane_of(st_b[s], i) : lane_of(st_a[s], i);
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < MAXC; c++) begin
      st_valid[c] = 1'b0;
      st_last[c]  = 1'b0;
      st_a[c]     = '0;
      st_b[c]     = '0;
      acc_exp[c]  = 1'b0;
    end
  endtask

  task automatic play(input int n);
    for (int c = 1; c <= n; c++) begin
      in_valid = st_valid[c];
      in_last  = st_last[c];
      in_a     = st_a[c];
      in_b     = st_b[c];
      @(posedge clk);
      #1;
      ob_a[c][0] = a1; ob_a[c][1] = a2; ob_a[c][2] = a3; ob_a[c][3] = a4;
      ob_b[c][0] = b1; ob_b[c][1] = b2; ob_b[c][2] = b3; ob_b[c][3] = b4;
      ob_done[c]  = done;
      ob_ready[c] = in_ready;
      ob_busy[c]  = busy;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
  endtask

  task automatic load_reference_frame(input bit with_bubble);
    logic [63:0] s [4];
    int          cyc [4];
    s[0] = pack4(16'h011c, 16'h058e, 16'h0000, 16'h0000);
    s[1] = pack4(16'h0239, 16'h06aa, 16'h011c, 16'h058e);
    s[2] = pack4(16'h0355, 16'h07c7, 16'h0239, 16'h06aa);
    s[3] = pack4(16'h0472, 16'h08e3, 16'h0355, 16'h07c7);
    cyc[0] = 1; cyc[1] = 2;
    cyc[2] = with_bubble ? 4 : 3;
    cyc[3] = with_bubble ? 5 : 4;
    clear_stim();
    for (int k = 0; k < 4; k++) begin
      st_valid[cyc[k]] = 1'b1;
      st_a[cyc[k]]     = s[k];
      st_b[cyc[k]]     = pack4(16'h011c, 16'h011c, 16'h011c, 16'h011c);
      acc_exp[cyc[k]]  = 1'b1;
    end
    st_last[cyc[3]] = 1'b1;
    if (with_bubble) st_a[3] = 64'hdead_beef_cafe_f00d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      in_a     = {$urandom, $urandom};
      in_b     = {$urandom, $urandom};
      @(posedge clk);
      #1;
    end
    checks++;
    if ({a1, a2, a3, a4, b1, b2, b3, b4} !== 128'h0) begin
      errors++;
      $display("FAIL reset_lanes: got %h want 0", {a1, a2, a3, a4, b1, b2, b3, b4});
    end
    checks++;
    if ({in_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_flags: ready/busy/done got %b want 100", {in_ready, busy, done});
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({a1, a4, b1, b4, in_ready, busy, done} !== {64'h0, 3'b100}) begin
      errors++;
      $display("FAIL reset_release: got %h want %h", {a1, a4, b1, b4, in_ready, busy, done},
               {64'h0, 3'b100});
    end
  endtask

  task automatic test_four_slices();
    logic [15:0] a1_ref [4];
    logic [15:0] a4_ref [4];
    a1_ref = '{16'h011c, 16'h0239, 16'h0355, 16'h0472};
    a4_ref = '{16'h0000, 16'h058e, 16'h06aa, 16'h07c7};
    load_reference_frame(1'b0);
    play(16);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ob_a[k+1][0] !== a1_ref[k]) begin
        errors++;
        $display("FAIL four_a1 cyc%0d: got %h want %h", k + 1, ob_a[k+1][0], a1_ref[k]);
      end
      checks++;
      if (ob_a[k+4][3] !== a4_ref[k]) begin
        errors++;
        $display("FAIL four_a4 cyc%0d: got %h want %h", k + 4, ob_a[k+4][3], a4_ref[k]);
      end
      checks++;
      if (ob_b[k+4][3] !== 16'h011c) begin
        errors++;
        $display("FAIL four_b4 cyc%0d: got %h want 011c", k + 4, ob_b[k+4][3]);
      end
    end
    for (int c = 1; c <= 16; c++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ob_a[c][i] !== exp_lane(1'b0, c, i) || ob_b[c][i] !== exp_lane(1'b1, c, i)) begin
          errors++;
          $display("FAIL four_lane%0d cyc%0d: got a=%h b=%h want a=%h b=%h", i, c, ob_a[c][i],
                   ob_b[c][i], exp_lane(1'b0, c, i), exp_lane(1'b1, c, i));
        end
      end
      checks++;
      if ({ob_done[c], ob_ready[c], ob_busy[c]} !== {c == 14, !(c >= 4 && c <= 13), c <= 13}) begin
        errors++;
        $display("FAIL four_flags cyc%0d: done/ready/busy got %b%b%b want %b%b%b", c, ob_done[c],
                 ob_ready[c], ob_busy[c], c == 14, !(c >= 4 && c <= 13), c <= 13);
      end
    end
  endtask

  task automatic test_bubble();
    load_reference_frame(1'b1);
    play(17);
    for (int c = 1; c <= 17; c++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ob_a[c][i] !== exp_lane(1'b0, c, i) || ob_b[c][i] !== exp_lane(1'b1, c, i)) begin
          errors++;
          $display("FAIL bubble_lane%0d cyc%0d: got a=%h b=%h want a=%h b=%h", i, c, ob_a[c][i],
                   ob_b[c][i], exp_lane(1'b0, c, i), exp_lane(1'b1, c, i));
        end
      end
      checks++;
      if ({ob_done[c], ob_ready[c], ob_busy[c]} !== {c == 15, !(c >= 5 && c <= 14), c <= 14}) begin
        errors++;
        $display("FAIL bubble_flags cyc%0d: done/ready/busy got %b%b%b want %b%b%b", c, ob_done[c],
                 ob_ready[c], ob_busy[c], c == 15, !(c >= 5 && c <= 14), c <= 14);
      end
    end
  endtask

  task automatic test_k1(input bit drive_in_drain);
    clear_stim();
    st_valid[1] = 1'b1;
    st_last[1]  = 1'b1;
    st_a[1]     = pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    st_b[1]     = pack4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    acc_exp[1]  = 1'b1;
    if (drive_in_drain) begin
      for (int c = 2; c <= 11; c++) begin
        st_valid[c] = 1'b1;
        st_last[c]  = 1'b1;
        st_a[c]     = 64'h5a5a_a5a5_1234_8765 + 64'(c);
        st_b[c]     = 64'hffff_0000_ffff_0000 + 64'(c);
      end
    end
    play(13);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ob_a[i+1][i] !== 16'(i + 1)) begin
        errors++;
        $display("FAIL k1_offset a%0d: got %h want %h", i + 1, ob_a[i+1][i], 16'(i + 1));
      end
    end
    for (int c = 1; c <= 13; c++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ob_a[c][i] !== exp_lane(1'b0, c, i) || ob_b[c][i] !== exp_lane(1'b1, c, i)) begin
          errors++;
          $display("FAIL k1_lane%0d cyc%0d drain_drive=%0d: got a=%h b=%h want a=%h b=%h", i, c,
                   drive_in_drain, ob_a[c][i], ob_b[c][i], exp_lane(1'b0, c, i),
                   exp_lane(1'b1, c, i));
        end
      end
      checks++;
      if ({ob_done[c], ob_ready[c], ob_busy[c]} !== {c == 11, !(c >= 1 && c <= 10), c <= 10}) begin
        errors++;
        $display("FAIL k1_flags cyc%0d drain_drive=%0d: done/ready/busy got %b%b%b want %b%b%b",
                 c, drive_in_drain, ob_done[c], ob_ready[c], ob_busy[c], c == 11,
                 !(c >= 1 && c <= 10), c <= 10);
      end
    end
  endtask

  task automatic test_back_to_back_frames();
    bit e_busy;
    clear_stim();
    st_a[1]  = pack4(16'h1001, 16'h1002, 16'h1003, 16'h1004);
    st_a[2]  = pack4(16'h2001, 16'h2002, 16'h2003, 16'h2004);
    st_a[13] = pack4(16'h3001, 16'h3002, 16'h3003, 16'h3004);
    st_a[14] = pack4(16'h4001, 16'h4002, 16'h4003, 16'h4004);
    foreach (st_a[c]) st_b[c] = ~st_a[c];
    for (int c = 1; c <= 14; c++) begin
      if (c == 1 || c == 2 || c == 13 || c == 14) begin
        st_valid[c] = 1'b1;
        acc_exp[c]  = 1'b1;
      end
    end
    st_last[2]  = 1'b1;
    st_last[14] = 1'b1;
    play(26);
    for (int c = 1; c <= 26; c++) begin
      e_busy = (c <= 11) || (c >= 13 && c <= 23);
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ob_a[c][i] !== exp_lane(1'b0, c, i) || ob_b[c][i] !== exp_lane(1'b1, c, i)) begin
          errors++;
          $display("FAIL frames_lane%0d cyc%0d: got a=%h b=%h want a=%h b=%h", i, c, ob_a[c][i],
                   ob_b[c][i], exp_lane(1'b0, c, i), exp_lane(1'b1, c, i));
        end
      end
      checks++;
      if ({ob_done[c], ob_ready[c], ob_busy[c]} !==
          {c == 12 || c == 24, !((c >= 2 && c <= 11) || (c >= 14 && c <= 23)), e_busy}) begin
        errors++;
        $display("FAIL frames_flags cyc%0d: done/ready/busy got %b%b%b want %b%b%b", c,
                 ob_done[c], ob_ready[c], ob_busy[c], c == 12 || c == 24,
                 !((c >= 2 && c <= 11) || (c >= 14 && c <= 23)), e_busy);
      end
    end
  endtask

  task automatic test_reset_mid_feed();
    in_valid = 1'b1;
    in_last  = 1'b0;
    in_a     = pack4(16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd);
    in_b     = pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if ({busy, in_ready, a1, a2} !== {2'b11, 16'haaaa, 16'hbbbb}) begin
      errors++;
      $display("FAIL midfeed_pre: got busy/ready/a1/a2 %h want %h", {busy, in_ready, a1, a2},
               {2'b11, 16'haaaa, 16'hbbbb});
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({a1, a2, a3, a4, b1, b2, b3, b4} !== 128'h0) begin
      errors++;
      $display("FAIL midfeed_async_lanes: got %h want 0", {a1, a2, a3, a4, b1, b2, b3, b4});
    end
    checks++;
    if ({in_ready, busy, done} !== 3'b100) begin
      errors++;
      $display("FAIL midfeed_async_flags: ready/busy/done got %b want 100", {in_ready, busy, done});
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({done, busy, in_ready, a4, b4} !== {3'b001, 32'h0}) begin
        errors++;
        $display("FAIL midfeed_after cyc%0d: done/busy/ready/a4/b4 got %h want %h", c,
                 {done, busy, in_ready, a4, b4}, {3'b001, 32'h0});
      end
    end
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_a     = '0;
    in_b     = '0;
    test_reset();
    test_four_slices();
    test_bubble();
    test_k1(1'b0);
    test_k1(1'b1);
    test_back_to_back_frames();
    test_reset_mid_feed();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Upstream feeder for the 4x4 systolic array `top`. It accepts one unskewed K-slice per handshake: column k of A (four 16-bit elements) and row k of B (four 16-bit elements). It drives the array's `a1..a4` and `b1..b4` inputs with the diagonal stagger the array needs, meaning lane i is delayed i extra cycles and bubbles are zero-filled. It signals `done` once the last slice has fully reached the array's PE(4,4) accumulator.

## Interface
- `DATA_W`, 16, element width of A/B lanes.
- `ARRAY_LAT`, 7, cycles from an element entering the array's lane-4 input until PE(4,4)'s accumulator contains its product.
- `CNT_W`, 4, width of the drain counter; must hold `3+ARRAY_LAT`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  slice on `in_a`/`in_b` is valid.
- `in_ready`  out  1  feeder can accept a slice this cycle.
- `in_last`  in  1  qualifies the final slice (k=K-1) of a frame.
- `in_a`  in  4*DATA_W  A[i][k]; bits [16i+15:16i] belong to lane i (i=0..3).
- `in_b`  in  4*DATA_W  B[k][j]; bits [16j+15:16j] belong to lane j.
- `a1`,`a2`,`a3`,`a4`  out  DATA_W each  skewed A lanes 0..3 to the array.
- `b1`,`b2`,`b3`,`b4`  out  DATA_W each  skewed B lanes 0..3 to the array.
- `busy`  out  1  frame in progress (state is not IDLE).
- `done`  out  1  one-cycle pulse: the frame's results on `c1..c16` are final.

## Operation
- Accept occurs on a rising edge with `in_valid && in_ready`.
- Lane i (A and B alike) is a chain of i+1 registers; stage 0 loads the lane-i element on accept, else 0.
- Outputs `a(i+1)`/`b(i+1)` are the last stage of lane i. Output delay from the accept edge is i+1 edges.
- An idle cycle (no accept) injects zeros into every lane's stage 0. This yields zero products in the array and keeps frame results unchanged.
- FSM states:
  - IDLE: `in_ready=1`, `busy=0`. Accept with `in_last=0` goes to FEED. Accept with `in_last=1` (K=1) goes to DRAIN.
  - FEED: `in_ready=1`, `busy=1`. Accept with `in_last=1` goes to DRAIN. `in_valid=0` stays in FEED and inserts bubbles.
  - DRAIN: `in_ready=0`, `busy=1`. On entry the drain counter loads `3+ARRAY_LAT` and decrements each edge. At 0 the FSM goes to IDLE and `done` is registered high for exactly one cycle.
- `in_last` is ignored unless an accept occurs.
- K is unbounded; no frame-length check is made.
- No arithmetic is performed; data passes bit-exact and unsigned/sign-agnostic.
- The feeder does not clear the array. Array accumulators are cleared by `rst` between frames.

## Timing
- Reset (`rst` low, async) forces:
  - all lane registers to 0, so `a1..a4` and `b1..b4` are 0;
  - state to IDLE, `busy=0`, `done=0`, `in_ready=1` immediately;
  - drain counter to 0.
- Reset mid-frame discards all in-flight data and any pending `done`. The first edge after release behaves as IDLE.
- `in_ready` is a combinational decode of state only. It never depends on `in_valid`.
- Slice accepted at edge E:
  - `a1`/`b1` show it after E;
  - `a2`/`b2` after E+1;
  - `a3`/`b3` after E+2;
  - `a4`/`b4` after E+3.
- Back-to-back accepts give continuous diagonals with no gaps, matching the array's expected wavefront.
- Last slice accepted at edge E: `done` is high during the cycle after edge E+3+ARRAY_LAT, i.e. 11 edges with defaults, and low otherwise.
- `in_ready` returns to 1 in the same cycle `done` is high. A new accept in that cycle is legal and starts the next frame.

## Test plan
- Reset: hold `rst=0` with random inputs, then release -> all lanes 0, `in_ready=1`, `busy=0`, `done=0`. Assert `rst` low mid-FEED -> outputs 0 asynchronously, before the next edge.
- Four back-to-back accepts:
  - in_a slices (lane 0..3): {011c,058e,0000,0000}, {0239,06aa,011c,058e}, {0355,07c7,0239,06aa}, {0472,08e3,0355,07c7};
  - in_b = 011c on all lanes;
  - `in_last` on the 4th slice.
  - Required: `a1` = 011c,0239,0355,0472 on cycles 1-4; `a4` = 0,058e,06aa,07c7 on cycles 4-7; `b4` = 011c on cycles 4-7; zeros elsewhere.
- Bubble: same frame with `in_valid=0` for one cycle between slices 2 and 3 -> every lane shows one zero between those elements at its own offset. `done` moves out by one cycle.
- K=1: a single accept with `in_last=1` and in_a={0001,0002,0003,0004} -> `a(i+1)`=000(i+1) exactly at offset i+1. `done` pulses after edge E+10; `in_ready=0` in between.
- Back-to-back frames: accept a new first slice in the `done` cycle -> accepted. FSM goes IDLE->FEED, with no lost or duplicated slice.
- Ignored input: `in_valid=1` during DRAIN -> no accept, lane stage 0 loads 0, `done` timing unchanged.
